// File: rtl/data_mem_master_pkg.sv
// Shared definitions for the data scratchpad load/store initiator.
// Holds the MEM-stage op encodings, the initiator FSM states, the access
// size classification and small helpers that decode an op into its size,
// direction and signedness.
package data_mem_master_pkg;

    // Op encodings as presented by the MEM stage on op_i
    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LBU = 3'b001,
        OP_LH  = 3'b010,
        OP_LHU = 3'b011,
        OP_LW  = 3'b100,
        OP_SB  = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } mem_op_e;

    // Initiator FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10,
        ERR    = 2'b11
    } state_e;

    // Access width classes
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    function automatic size_e op_size(input mem_op_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic op_is_store(input mem_op_e op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic op_is_signed(input mem_op_e op);
        return op inside {OP_LB, OP_LH};
    endfunction

endpackage

// File: rtl/data_mem_master_lane_align.sv
// Combinational lane steering for the data RAM (big-endian lane order).
// Ports:
//   op         - access op (size, direction, signedness)
//   offset     - byte offset within the word (addr[1:0])
//   wdata      - right-justified store data
//   rdata      - raw word read from the RAM
//   sel        - byte enables, bit3 = [31:24]
//   store_data - store data replicated across all lanes
//   load_data  - selected lane, sign- or zero-extended
//   misalign   - halfword on an odd byte, or word not on a word boundary
module data_mem_master_lane_align
    import data_mem_master_pkg::*;
(
    input  mem_op_e     op,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sign_ext;

    // Offset 00 is the most significant lane
    always_comb begin
        case (offset)
            2'b00:   byte_lane = rdata[31:24];
            2'b01:   byte_lane = rdata[23:16];
            2'b10:   byte_lane = rdata[15:8];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = offset[1] ? rdata[15:0] : rdata[31:16];
        sign_ext  = op_is_signed(op);
    end

    // Stores replicate the low byte/half into every lane so the byte
    // enables alone decide what lands in the RAM
    always_comb begin
        sel        = 4'b0000;
        store_data = wdata;
        load_data  = rdata;
        misalign   = 1'b0;
        case (op_size(op))
            SZ_BYTE: begin
                sel        = 4'b1000 >> offset;
                store_data = {4{wdata[7:0]}};
                load_data  = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            end
            SZ_HALF: begin
                misalign   = offset[0];
                sel        = offset[1] ? 4'b0011 : 4'b1100;
                store_data = {2{wdata[15:0]}};
                load_data  = {{16{sign_ext & half_lane[15]}}, half_lane};
            end
            default: begin
                misalign   = |offset;
                sel        = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_master.sv
// Load/store initiator between the MEM pipeline stage and the data
// scratchpad RAM. Latches one request, holds the RAM access phase for
// WAIT_CYCLES+1 cycles, then pulses done_o (or misalign_o for a misaligned
// request, which never reaches the RAM).
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   req_i, op_i, addr_i,
//   wdata_i               - request from the MEM stage (sampled in IDLE)
//   busy_o                - high whenever a request is in flight
//   done_o, misalign_o    - one-cycle completion / error pulses
//   rdata_o               - last formatted load result
//   ram_*                 - data RAM pins (ram_data_i is combinational)
module data_mem_master
    import data_mem_master_pkg::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [2:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              misalign_o,
    output logic [31:0]       rdata_o,
    output logic              ram_ce_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [3:0]        ram_sel_o,
    output logic [31:0]       ram_data_o,
    input  logic [31:0]       ram_data_i
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_e            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    mem_op_e           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              accept;
    logic              capture;

    mem_op_e           align_op;
    logic [1:0]        align_off;
    logic [31:0]       align_wdata;
    logic [3:0]        lane_sel;
    logic [31:0]       lane_store;
    logic [31:0]       lane_load;
    logic              lane_misalign;

    // In IDLE the aligner judges the live request for misalignment; once a
    // request is accepted it only ever sees the latched copy, so the MEM
    // stage is free to change its inputs while we are busy
    assign align_op    = (state == IDLE) ? mem_op_e'(op_i) : op_q;
    assign align_off   = (state == IDLE) ? addr_i[1:0]     : addr_q[1:0];
    assign align_wdata = (state == IDLE) ? wdata_i         : wdata_q;

    data_mem_master_lane_align u_lane_align (
        .op         (align_op),
        .offset     (align_off),
        .wdata      (align_wdata),
        .rdata      (ram_data_i),
        .sel        (lane_sel),
        .store_data (lane_store),
        .load_data  (lane_load),
        .misalign   (lane_misalign)
    );

    // State and wait counter; reset forces IDLE at once so the RAM pins
    // (decoded from the state) drop without waiting for a clock edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Request latch, loaded only on the IDLE -> ACCESS transition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= OP_LB;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            op_q    <= mem_op_e'(op_i);
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
        end
    end

    // Load result register; stores and misaligned requests leave it alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (capture) begin
            rdata_q <= lane_load;
        end
    end

    assign rdata_o = rdata_q;

    // Next-state and output decode; RAM pins are only live in ACCESS
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        accept     = 1'b0;
        capture    = 1'b0;
        busy_o     = 1'b1;
        done_o     = 1'b0;
        misalign_o = 1'b0;
        ram_ce_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_sel_o  = 4'b0000;
        ram_data_o = '0;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (req_i) begin
                    if (lane_misalign) begin
                        state_nx = ERR;
                    end else begin
                        state_nx = ACCESS;
                        cnt_nx   = WAIT_INIT;
                        accept   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                ram_ce_o   = 1'b1;
                ram_we_o   = op_is_store(op_q);
                ram_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
                ram_sel_o  = lane_sel;
                ram_data_o = op_is_store(op_q) ? lane_store : '0;
                if (cnt != 4'd0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    capture  = !op_is_store(op_q);
                    state_nx = DONE;
                end
            end
            DONE: begin
                done_o   = 1'b1;
                state_nx = IDLE;
            end
            ERR: begin
                misalign_o = 1'b1;
                state_nx   = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_data_mem_master.sv
// Self-checking bench for data_mem_master: one instance with no wait
// states and one with three, each attached to its own behavioural RAM.
module tb_data_mem_master;

    localparam logic [2:0] LB = 3'b000, LBU = 3'b001, LH = 3'b010, LHU = 3'b011,
                           LW = 3'b100, SB = 3'b101, SH = 3'b110, SW = 3'b111;

    typedef struct {
        logic        is_err;
        logic        is_store;
        logic [31:0] rdata;
        int          lat;
        int          ce_cycles;
        int          busy_cycles;
        logic [3:0]  sel;
        logic [31:0] wd;
        logic [31:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_clear;
    logic        req [2];
    logic [2:0]  op [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic        busy [2];
    logic        done [2];
    logic        mis [2];
    logic [31:0] rdata [2];
    logic        ce [2];
    logic        we [2];
    logic [31:0] raddr [2];
    logic [3:0]  sel [2];
    logic [31:0] rwd [2];
    logic [31:0] rrd [2];
    logic [31:0] mem [2][64];
    logic [31:0] last_rd [2];

    exp_t sb_q[$];
    int   num_checks = 0;
    int   num_fail   = 0;

    always #5 clk = ~clk;

    data_mem_master #(.WAIT_CYCLES(0), .ADDR_W(32)) u_dut0 (
        .clk(clk), .rst(rst), .req_i(req[0]), .op_i(op[0]), .addr_i(addr[0]),
        .wdata_i(wdata[0]), .busy_o(busy[0]), .done_o(done[0]), .misalign_o(mis[0]),
        .rdata_o(rdata[0]), .ram_ce_o(ce[0]), .ram_we_o(we[0]), .ram_addr_o(raddr[0]),
        .ram_sel_o(sel[0]), .ram_data_o(rwd[0]), .ram_data_i(rrd[0])
    );

    data_mem_master #(.WAIT_CYCLES(3), .ADDR_W(32)) u_dut1 (
        .clk(clk), .rst(rst), .req_i(req[1]), .op_i(op[1]), .addr_i(addr[1]),
        .wdata_i(wdata[1]), .busy_o(busy[1]), .done_o(done[1]), .misalign_o(mis[1]),
        .rdata_o(rdata[1]), .ram_ce_o(ce[1]), .ram_we_o(we[1]), .ram_addr_o(raddr[1]),
        .ram_sel_o(sel[1]), .ram_data_o(rwd[1]), .ram_data_i(rrd[1])
    );

    // Combinational RAM read, byte-enabled write on every edge with ce & we
    assign rrd[0] = mem[0][raddr[0][7:2]];
    assign rrd[1] = mem[1][raddr[1][7:2]];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_clear) begin
                for (int i = 0; i < 64; i++) mem[d][i] <= 32'h0;
            end else if (ce[d] && we[d]) begin
                for (int b = 0; b < 4; b++)
                    if (sel[d][b]) mem[d][raddr[d][7:2]][8*b +: 8] <= rwd[d][8*b +: 8];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Issue one request on DUT d, then follow it cycle by cycle until the
    // completion pulse pops its expectation from the scoreboard
    task automatic applyStimulus(input int d, input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] w, input logic exp_err,
                                 input logic [31:0] exp_rd, input logic [3:0] exp_sel,
                                 input logic [31:0] exp_wd);
        exp_t e;
        exp_t got;
        int   wc;
        int   ce_n;
        int   busy_n;
        bit   seen;
        wc            = (d == 0) ? 0 : 3;
        e.is_err      = exp_err;
        e.is_store    = o[2] & (o[1] | o[0]);
        e.rdata       = (exp_err || e.is_store) ? last_rd[d] : exp_rd;
        e.lat         = exp_err ? 1 : wc + 2;
        e.ce_cycles   = exp_err ? 0 : wc + 1;
        e.busy_cycles = exp_err ? 1 : wc + 2;
        e.sel         = exp_sel;
        e.wd          = exp_wd;
        e.addr        = {a[31:2], 2'b00};
        sb_q.push_back(e);

        @(negedge clk);
        req[d] = 1'b1; op[d] = o; addr[d] = a; wdata[d] = w;
        @(posedge clk);
        #1;
        req[d] = 1'b0; op[d] = ~o; addr[d] = $urandom; wdata[d] = $urandom;
        ce_n = 0; busy_n = 0; seen = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (busy[d]) busy_n++;
            if (ce[d]) begin
                ce_n++;
                checkOutput("ram_addr", raddr[d], sb_q[0].addr);
                checkOutput("ram_we", {31'b0, we[d]}, {31'b0, sb_q[0].is_store});
                checkOutput("ram_sel", {28'b0, sel[d]}, {28'b0, sb_q[0].sel});
                if (sb_q[0].is_store) checkOutput("ram_data", rwd[d], sb_q[0].wd);
            end
            if (done[d] || mis[d]) begin
                got  = sb_q.pop_front();
                seen = 1;
                checkOutput("latency", k, got.lat);
                checkOutput("done_pulse", {31'b0, done[d]}, {31'b0, !got.is_err});
                checkOutput("misalign_pulse", {31'b0, mis[d]}, {31'b0, got.is_err});
                checkOutput("rdata", rdata[d], got.rdata);
                checkOutput("ce_cycles", ce_n, got.ce_cycles);
                checkOutput("busy_cycles", busy_n, got.busy_cycles);
                if (!got.is_err && !got.is_store) last_rd[d] = got.rdata;
            end else if (k <= wc) begin
                req[d] = 1'($urandom_range(0, 1));
            end else begin
                req[d] = 1'b0;
            end
        end
        req[d] = 1'b0;
        if (!seen) begin
            checkOutput("timeout", 32'd0, 32'd1);
            sb_q.delete();
        end
        @(negedge clk);
        checkOutput("pulse_end", {31'b0, done[d] | mis[d] | busy[d]}, 32'd0);
    endtask

    task automatic checkIdlePins(input string tag, input int d);
        checkOutput({tag, "_ce"}, {31'b0, ce[d]}, 32'd0);
        checkOutput({tag, "_we"}, {31'b0, we[d]}, 32'd0);
        checkOutput({tag, "_sel"}, {28'b0, sel[d]}, 32'd0);
        checkOutput({tag, "_addr"}, raddr[d], 32'd0);
        checkOutput({tag, "_wdata"}, rwd[d], 32'd0);
        checkOutput({tag, "_busy"}, {31'b0, busy[d]}, 32'd0);
        checkOutput({tag, "_done"}, {31'b0, done[d]}, 32'd0);
        checkOutput({tag, "_mis"}, {31'b0, mis[d]}, 32'd0);
        checkOutput({tag, "_rdata"}, rdata[d], 32'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit stray_done;
        rst = 1'b1;
        mem_clear = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; op[d] = 3'b0; addr[d] = 32'h0; wdata[d] = 32'h0; last_rd[d] = 32'h0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_clear = 1'b0;
        checkIdlePins("reset0", 0);
        checkIdlePins("reset1", 1);
        rst = 1'b0;

        // Word store / load, then byte lanes with replication and extension
        applyStimulus(0, SW,  32'h10, 32'hDEADBEEF, 0, 32'h0,        4'b1111, 32'hDEADBEEF);
        applyStimulus(0, LW,  32'h10, 32'h0,        0, 32'hDEADBEEF, 4'b1111, 32'h0);
        applyStimulus(0, SB,  32'h13, 32'h123456A5, 0, 32'h0,        4'b0001, 32'hA5A5A5A5);
        applyStimulus(0, LW,  32'h10, 32'h0,        0, 32'hDEADBEA5, 4'b1111, 32'h0);
        applyStimulus(0, LB,  32'h13, 32'h0,        0, 32'hFFFFFFA5, 4'b0001, 32'h0);
        applyStimulus(0, LBU, 32'h13, 32'h0,        0, 32'h000000A5, 4'b0001, 32'h0);
        applyStimulus(0, SH,  32'h12, 32'h00008001, 0, 32'h0,        4'b0011, 32'h80018001);
        applyStimulus(0, LH,  32'h12, 32'h0,        0, 32'hFFFF8001, 4'b0011, 32'h0);
        applyStimulus(0, LHU, 32'h12, 32'h0,        0, 32'h00008001, 4'b0011, 32'h0);
        applyStimulus(0, LH,  32'h10, 32'h0,        0, 32'hFFFFDEAD, 4'b1100, 32'h0);
        applyStimulus(0, LB,  32'h10, 32'h0,        0, 32'hFFFFFFDE, 4'b1000, 32'h0);
        applyStimulus(0, LBU, 32'h11, 32'h0,        0, 32'h000000AD, 4'b0100, 32'h0);
        applyStimulus(0, LB,  32'h12, 32'h0,        0, 32'hFFFFFF80, 4'b0010, 32'h0);
        applyStimulus(0, SB,  32'h10, 32'h0000007F, 0, 32'h0,        4'b1000, 32'h7F7F7F7F);
        applyStimulus(0, LHU, 32'h10, 32'h0,        0, 32'h00007FAD, 4'b1100, 32'h0);
        applyStimulus(0, LB,  32'h10, 32'h0,        0, 32'h0000007F, 4'b1000, 32'h0);
        applyStimulus(0, SH,  32'h10, 32'hABCD1234, 0, 32'h0,        4'b1100, 32'h12341234);
        applyStimulus(0, LW,  32'h10, 32'h0,        0, 32'h12348001, 4'b1111, 32'h0);

        // Misaligned requests never touch the RAM and leave rdata alone
        applyStimulus(0, LW,  32'h11, 32'h0,        1, 32'h0, 4'b0000, 32'h0);
        applyStimulus(0, SH,  32'h13, 32'h0000FFFF, 1, 32'h0, 4'b0000, 32'h0);
        applyStimulus(0, SW,  32'h12, 32'hFFFFFFFF, 1, 32'h0, 4'b0000, 32'h0);
        applyStimulus(0, LHU, 32'h11, 32'h0,        1, 32'h0, 4'b0000, 32'h0);
        checkOutput("mem_after_misalign", mem[0][4], 32'h12348001);
        applyStimulus(0, LW,  32'h10, 32'h0,        0, 32'h12348001, 4'b1111, 32'h0);

        // Wait states: ce for 4 cycles, busy for 5, done at cycle 5
        applyStimulus(1, SW,  32'h20, 32'hCAFEF00D, 0, 32'h0,        4'b1111, 32'hCAFEF00D);
        applyStimulus(1, LW,  32'h20, 32'h0,        0, 32'hCAFEF00D, 4'b1111, 32'h0);
        applyStimulus(1, LBU, 32'h22, 32'h0,        0, 32'h000000F0, 4'b0010, 32'h0);

        // Reset while a store is in ACCESS, before any write edge
        @(negedge clk);
        req[1] = 1'b1; op[1] = SW; addr[1] = 32'h20; wdata[1] = 32'h12345678;
        @(posedge clk);
        #1;
        req[1] = 1'b0;
        @(negedge clk);
        checkOutput("rst_pre_ce", {31'b0, ce[1]}, 32'd1);
        rst = 1'b1;
        #1;
        checkIdlePins("midrst", 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        stray_done = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done[1] || busy[1] || ce[1]) stray_done = 1;
        end
        checkOutput("no_done_after_rst", {31'b0, stray_done}, 32'd0);
        checkOutput("mem_after_rst", mem[1][8], 32'hCAFEF00D);
        applyStimulus(1, LW,  32'h20, 32'h0,        0, 32'hCAFEF00D, 4'b1111, 32'h0);
        applyStimulus(0, LW,  32'h10, 32'h0,        0, 32'h12348001, 4'b1111, 32'h0);

        checkOutput("scoreboard_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
